fwd_hazard_unit: RTL and testbench



---
 rtl/fwd_pkg.sv | 18 +
 rtl/fwd_port_match.sv | 29 ++
 rtl/fwd_hazard_unit.sv | 106 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding / load-use hazard unit.
package fwd_pkg;

  localparam int unsigned FWD_RF    = 0;
  localparam int unsigned FWD_EXMEM = 1;
  localparam int unsigned FWD_MEMWB = 2;

  // Control bits of a tag slot; rd and src travel alongside as parameter-sized vectors.
  typedef struct packed {
    logic valid;
    logic regwrite;
  } slot_ctl_t;

  function automatic int unsigned sel_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Priority match of one EX source operand against the post-EX producer slots.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = sel_width(FWD_STAGES)
) (
  input  logic [REG_AW-1:0]                 src,
  input  logic                              ex_valid,
  input  slot_ctl_t [FWD_STAGES:1]          stg_ctl,
  input  logic [FWD_STAGES:1][REG_AW-1:0]   stg_rd,
  output logic [SEL_W-1:0]                  sel
);

  // Walk from the oldest stage to the youngest so the nearest producer overwrites.
  always_comb begin
    sel = SEL_W'(FWD_RF);
    if (ex_valid && (src != '0)) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (stg_ctl[k].valid && stg_ctl[k].regwrite && (stg_rd[k] != '0) &&
            (stg_rd[k] == src)) begin
          sel = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall unit with an internal destination-tag pipeline.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_RP     = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SEL_W      = sel_width(FWD_STAGES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [NUM_RP*REG_AW-1:0]   id_src,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_memread,
  input  logic                       flush,
  output logic [NUM_RP*SEL_W-1:0]    fwd_sel,
  output logic                       stall,
  output logic [CNT_W-1:0]           stall_cnt
);

  slot_ctl_t                       ex_ctl_q, ex_ctl_d;
  logic                            ex_memread_q, ex_memread_d;
  logic [REG_AW-1:0]               ex_rd_q, ex_rd_d;
  logic [NUM_RP*REG_AW-1:0]        ex_src_q, ex_src_d;
  // memread is only consulted in EX; loads deeper in the pipe forward like any producer.
  slot_ctl_t [FWD_STAGES:1]        stg_ctl_q;
  logic [FWD_STAGES:1][REG_AW-1:0] stg_rd_q;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  logic src_hit;
  logic bubble;

  always_comb begin
    src_hit = 1'b0;
    for (int p = 0; p < NUM_RP; p++) begin
      if (id_src[p*REG_AW +: REG_AW] == ex_rd_q) src_hit = 1'b1;
    end
  end

  assign stall = id_valid & ex_ctl_q.valid & ex_memread_q & ex_ctl_q.regwrite &
                 (ex_rd_q != '0) & src_hit;
  assign bubble = stall | flush | ~id_valid;

  always_comb begin
    ex_ctl_d     = '0;
    ex_memread_d = 1'b0;
    ex_rd_d      = '0;
    ex_src_d     = '0;
    if (!bubble) begin
      ex_ctl_d.valid    = 1'b1;
      ex_ctl_d.regwrite = id_regwrite;
      ex_memread_d      = id_memread;
      ex_rd_d           = id_rd;
      ex_src_d          = id_src;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctl_q     <= '0;
      ex_memread_q <= 1'b0;
      ex_rd_q      <= '0;
      ex_src_q     <= '0;
      stg_ctl_q    <= '0;
      stg_rd_q     <= '0;
      cnt_q        <= '0;
    end else begin
      ex_ctl_q     <= ex_ctl_d;
      ex_memread_q <= ex_memread_d;
      ex_rd_q      <= ex_rd_d;
      ex_src_q     <= ex_src_d;
      stg_ctl_q[1] <= ex_ctl_q;
      stg_rd_q[1]  <= ex_rd_q;
      for (int k = 2; k <= FWD_STAGES; k++) begin
        stg_ctl_q[k] <= stg_ctl_q[k-1];
        stg_rd_q[k]  <= stg_rd_q[k-1];
      end
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

  for (genvar p = 0; p < NUM_RP; p++) begin : g_port
    fwd_port_match #(
      .REG_AW     (REG_AW),
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
    ) u_match (
      .src      (ex_src_q[p*REG_AW +: REG_AW]),
      .ex_valid (ex_ctl_q.valid),
      .stg_ctl  (stg_ctl_q),
      .stg_rd   (stg_rd_q),
      .sel      (fwd_sel[p*SEL_W +: SEL_W])
    );
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: an instruction-history model predicts each cycle's outputs.
module tb_fwd_hazard_unit;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned NUM_RP = 2;
  localparam int unsigned FS     = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SEL_W  = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     id_valid;
  logic [NUM_RP*REG_AW-1:0] id_src;
  logic [REG_AW-1:0]        id_rd;
  logic                     id_regwrite;
  logic                     id_memread;
  logic                     flush;
  logic [NUM_RP*SEL_W-1:0]  fwd_sel;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;

  fwd_hazard_unit #(
    .REG_AW     (REG_AW),
    .NUM_RP     (NUM_RP),
    .FWD_STAGES (FS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] s0;
    logic [4:0] s1;
  } ins_t;

  typedef struct packed {
    logic [NUM_RP*SEL_W-1:0] sel;
    logic                    stl;
    logic [CNT_W-1:0]        cnt;
  } exp_t;

  ins_t             hist [0:FS];   // hist[0] = EX, hist[k] = k stages after EX
  logic [CNT_W-1:0] cnt_m;
  exp_t             sb [$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SEL_W-1:0] model_sel(input logic [4:0] src);
    logic [SEL_W-1:0] s;
    logic             found;
    s     = '0;
    found = 1'b0;
    if (hist[0].v && src != 5'd0) begin
      for (int k = 1; k <= FS; k++) begin
        if (!found && hist[k].v && hist[k].rw && hist[k].rd != 5'd0 && hist[k].rd == src) begin
          s     = SEL_W'(k);
          found = 1'b1;
        end
      end
    end
    return s;
  endfunction

  function automatic exp_t model_expect(input ins_t cur);
    exp_t e;
    e.sel = {model_sel(hist[0].s1), model_sel(hist[0].s0)};
    e.stl = cur.v && hist[0].v && hist[0].mr && hist[0].rw && hist[0].rd != 5'd0 &&
            (hist[0].rd == cur.s0 || hist[0].rd == cur.s1);
    e.cnt = cnt_m;
    return e;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k <= FS; k++) hist[k] = '0;
    cnt_m = '0;
  endfunction

  ins_t cur_ins;
  logic cur_fl;
  logic cur_stl;

  task automatic drive_check(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                             input logic [4:0] s0, input logic [4:0] s1, input logic fl);
    exp_t e;
    exp_t got_e;
    @(negedge clk);
    id_valid    = v;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_src      = {s1, s0};
    flush       = fl;
    cur_ins     = '{v: v, rw: rw, mr: mr, rd: rd, s0: s0, s1: s1};
    cur_fl      = fl;
    e           = model_expect(cur_ins);
    cur_stl     = e.stl;
    sb.push_back(e);
    #1;
    got_e = sb.pop_front();
    check_eq("fwd_sel", 32'(fwd_sel), 32'(got_e.sel));
    check_eq("stall", 32'(stall), 32'(got_e.stl));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(got_e.cnt));
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = FS; k >= 1; k--) hist[k] = hist[k-1];
    hist[0] = (cur_stl || cur_fl || !cur_ins.v) ? '0 : cur_ins;
    if (cur_stl && cnt_m != '1) cnt_m = cnt_m + CNT_W'(1);
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [4:0] s0, input logic [4:0] s1, input logic fl);
    drive_check(v, rd, rw, mr, s0, s1, fl);
    advance();
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    id_valid    = 1'b0;
    id_src      = '0;
    id_rd       = '0;
    id_regwrite = 1'b0;
    id_memread  = 1'b0;
    flush       = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("reset_sel", 32'(fwd_sel), 32'd0);
    check_eq("reset_stall", 32'(stall), 32'd0);
    check_eq("reset_cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    nop();

    // add r3; sub r4,r3,r1
    issue(1, 3, 1, 0, 1, 2, 0);
    issue(1, 4, 1, 0, 3, 1, 0);
    nop(); nop(); nop();
    // add r3; nop; or r5,r1,r3
    issue(1, 3, 1, 0, 1, 2, 0);
    nop();
    issue(1, 5, 1, 0, 1, 3, 0);
    nop(); nop(); nop();
    // double write to r3, nearest wins
    issue(1, 3, 1, 0, 1, 2, 0);
    issue(1, 3, 1, 0, 4, 5, 0);
    issue(1, 6, 1, 0, 3, 3, 0);
    nop(); nop(); nop();
    // lw r2; add r7,r2,r2 held in ID across the stall
    issue(1, 2, 1, 1, 1, 0, 0);
    issue(1, 7, 1, 0, 2, 2, 0);
    issue(1, 7, 1, 0, 2, 2, 0);
    nop(); nop(); nop();
    // writes to r0 never forward or stall
    issue(1, 0, 1, 0, 1, 1, 0);
    issue(1, 0, 1, 1, 1, 1, 0);
    issue(1, 8, 1, 0, 0, 0, 0);
    issue(1, 8, 1, 0, 0, 0, 0);
    nop(); nop(); nop();
    // flushed load leaves no hazard
    issue(1, 2, 1, 1, 1, 0, 1);
    issue(1, 7, 1, 0, 2, 2, 0);
    nop(); nop(); nop();
    // saturate the counter: a self-dependent load stalls every other cycle
    for (int i = 0; i < 2 * ((1 << CNT_W) + 3); i++) issue(1, 2, 1, 1, 2, 2, 0);
    nop(); nop();
    // random traffic on a small register set
    for (int i = 0; i < 200; i++) begin
      issue($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0);
    end
    // build a live hazard, then reset asynchronously between edges
    for (int i = 0; i < 40; i++) issue(1, 2, 1, 1, 2, 2, 0);
    issue(1, 3, 1, 0, 1, 2, 0);
    issue(1, 2, 1, 1, 3, 0, 0);
    drive_check(1, 7, 1, 0, 2, 2, 0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_sel", 32'(fwd_sel), 32'd0);
    check_eq("async_rst_stall", 32'(stall), 32'd0);
    check_eq("async_rst_cnt", 32'(stall_cnt), 32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1, 9, 1, 0, 2, 3, 0);
    nop(); nop(); nop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
